axi_lite_uart_regs: RTL
=======================

AXI_LITE_UART_REGS -- requirements
Module: axi_lite_uart_regs

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4, TX FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter BAUD_RST, default 434, reset value of baud divisor.
REQ-003 SHALL have the port clk, input, 1 bit: the single clock.
REQ-004 SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have the port axi, axi_lite_if.slave modport, -: AXI-lite responder side; this block answers the master modport.
REQ-006 SHALL have the port tx_data, output, 8 bits: byte to UART transmitter.
REQ-007 SHALL have the port tx_valid, output, 1 bit: tx_data valid.
REQ-008 SHALL have the port tx_ready, input, 1 bit: transmitter accepts byte.
REQ-009 SHALL have the port rx_data, input, 8 bits: byte from UART receiver.
REQ-010 SHALL have the port rx_valid, input, 1 bit: one-cycle strobe, non-stallable.
REQ-011 SHALL have the port baud_div, output, 16 bits: divisor for the UART baud generator.

Function
REQ-012 SHALL decode axi addr[7:2], ignore addr[1:0] and addr[31:8], and map 0x00 TXDATA(W), 0x04 RXDATA(R), 0x08 STATUS(R), 0x0C CTRL(RW), 0x10 BAUD(RW).
REQ-013 SHALL respond to any other offset with DECERR: reads return 0 and writes have no effect.
REQ-014 SHALL respond with SLVERR to a write to RXDATA/STATUS or a read of TXDATA, with no side effect and read data 0.
REQ-015 SHALL drive awready high when no AW is latched and bvalid is low; wready follows the same rule with W; AW and W arrive in either order or together.
REQ-016 SHALL perform the write in the cycle after both AW and W are latched, assert bvalid the same cycle, and hold bresp/bvalid until bready, then clear both latches.
REQ-017 SHALL drive arready high while rvalid is low, register rdata/rresp on the accept, assert rvalid the next cycle, and hold them until rready.
REQ-018 SHALL run the read and write channels fully independently; simultaneous accepts are both legal.
REQ-019 SHALL push wdata[7:0] into the TX FIFO on a TXDATA write with wstrb[0]=1 and FIFO not full (OKAY); full SHALL give SLVERR with the byte dropped; wstrb[0]=0 SHALL give OKAY with no push.
REQ-020 SHALL evaluate full for a push on pre-cycle state: a push to a full FIFO in the same cycle as a pop is still refused.
REQ-021 SHALL set tx_valid = FIFO not empty AND CTRL.tx_en, set tx_data = FIFO head, and pop on tx_valid&&tx_ready; tx_data is stable while tx_valid&&!tx_ready.
REQ-022 SHALL load rx_data into a 1-byte holding register on rx_valid and set rx_full.
REQ-023 SHALL set sticky rx_overrun and keep the old byte when rx_valid arrives with rx_full set and no RXDATA read accepted that cycle.
REQ-024 SHALL, on an RXDATA read accept, return {24'b0, byte} OKAY and clear rx_full; if rx_full=0 it SHALL return 0 with SLVERR.
REQ-025 SHALL, on a simultaneous RXDATA read accept and rx_valid, return the old byte, load the new byte, keep rx_full=1, and not set overrun.
REQ-026 SHALL return STATUS = {28'b0, rx_overrun, rx_full, tx_empty, tx_full}, bits 3..0.
REQ-027 SHALL define CTRL bit0 as tx_en (RW) and bit1 as write-1-to-clear rx_overrun (reads 0); other bits read 0.
REQ-028 SHALL apply CTRL/BAUD writes per wstrb byte lane, with BAUD[15:0] = baud_div and upper bits reading 0.
REQ-029 SHALL drive the same rx_overrun clear from CTRL bit1 even when it coincides with a new overrun event; set wins.

Reset
REQ-030 SHALL, on rst_n low asynchronously, force: all AXI ready/valid outputs 0, bresp/rresp OKAY, rdata 0, FIFO empty, tx_valid 0, tx_data 0, rx_full 0, rx_overrun 0, tx_en 1, baud_div BAUD_RST.
REQ-031 SHALL discard any in-flight transaction when reset arrives mid-transaction; no response is issued after release.
REQ-032 SHALL release reset with no spurious tx_valid or bvalid/rvalid pulse.

Structure
REQ-033 SHALL take resp_t (OKAY/EXOKAY/SLVERR/DECERR) and strb_t from axi_lite_pkg.
REQ-034 SHALL place register offset constants and STATUS/CTRL bit indices in axi_lite_pkg.
REQ-035 SHALL implement the TX FIFO as one sub-module, sync_fifo, parameterised by width and depth, with full/empty flags.

Verification
REQ-036 SHALL cover: AW two cycles before W, TXDATA write 0x41 -> bvalid one cycle after W, OKAY, tx_valid with tx_data=0x41.
REQ-037 SHALL cover: tx_ready=0, five TXDATA writes with TX_DEPTH=4 -> four OKAY, fifth SLVERR, STATUS=0x1.
REQ-038 SHALL cover: rx_valid with 0x55 then 0x66 without a read -> STATUS bit3=1, RXDATA read returns 0x55 OKAY, next read returns 0 SLVERR.
REQ-039 SHALL cover: RXDATA read accept coinciding with rx_valid 0x77 while holding 0x55 -> rdata 0x55, rx_full stays 1, no overrun.
REQ-040 SHALL cover: read 0x14 -> DECERR rdata 0; BAUD write 0x0000ABCD with wstrb 0001 from reset -> baud_div=0x01CD.
REQ-041 SHALL cover: rst_n low while bvalid pending with bready=0 -> bvalid 0 immediately, baud_div=434, FIFO empty.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite response/strobe types plus the UART register map used by
// the interface, the register block and the testbench.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef logic [3:0] strb_t;

    localparam logic [7:0] OFS_TXDATA = 8'h00;
    localparam logic [7:0] OFS_RXDATA = 8'h04;
    localparam logic [7:0] OFS_STATUS = 8'h08;
    localparam logic [7:0] OFS_CTRL   = 8'h0C;
    localparam logic [7:0] OFS_BAUD   = 8'h10;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_OVERRUN = 3;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_OVR_CLR  = 1;

    typedef enum logic [2:0] {
        REG_TXDATA,
        REG_RXDATA,
        REG_STATUS,
        REG_CTRL,
        REG_BAUD,
        REG_NONE
    } reg_sel_t;

    // Takes the word index addr[7:2]; byte-lane and high address bits never matter.
    function automatic reg_sel_t decode_reg(input logic [5:0] word);
        reg_sel_t sel;
        case ({word, 2'b00})
            OFS_TXDATA: sel = REG_TXDATA;
            OFS_RXDATA: sel = REG_RXDATA;
            OFS_STATUS: sel = REG_STATUS;
            OFS_CTRL:   sel = REG_CTRL;
            OFS_BAUD:   sel = REG_BAUD;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle with 32-bit address/data; master drives requests,
// slave drives readies and responses.
interface axi_lite_if;
    import axi_lite_pkg::*;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    strb_t       wstrb;
    logic        wvalid;
    logic        wready;
    resp_t       bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    resp_t       rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; head reads 0 when empty.
// Push/pop requests are qualified internally against pre-cycle full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes wrapped-full from empty.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/axi_lite_uart_regs.sv
// AXI-lite register front end for a UART: TX byte FIFO, 1-byte RX holding
// register with sticky overrun, control and baud divisor registers.
module axi_lite_uart_regs
    import axi_lite_pkg::*;
#(
    parameter int          TX_DEPTH = 4,
    parameter logic [15:0] BAUD_RST = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_lite_if.slave   axi,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] baud_div
);

    logic        live_reg;
    logic        aw_latched_reg;
    reg_sel_t    aw_sel_reg;
    logic        w_latched_reg;
    logic [15:0] wdata_reg;
    logic [1:0]  wstrb_reg;
    logic        bvalid_reg;
    resp_t       bresp_reg;
    resp_t       bresp_next;
    logic        rvalid_reg;
    resp_t       rresp_reg;
    resp_t       rresp_next;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_next;
    logic        tx_en_reg;
    logic        rx_full_reg;
    logic        rx_overrun_reg;
    logic [7:0]  rx_byte_reg;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, write_fire;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic        ctrl_we, ovr_clr, ovr_set, rx_read;
    logic [1:0]  baud_we;
    logic [7:0]  baud_lane [2];
    reg_sel_t    ar_sel;
    logic        unused_bits;

    // Readies stay low through reset and for the first clock after release.
    assign axi.awready = live_reg && !aw_latched_reg && !bvalid_reg;
    assign axi.wready  = live_reg && !w_latched_reg && !bvalid_reg;
    assign axi.arready = live_reg && !rvalid_reg;
    assign axi.bvalid  = bvalid_reg;
    assign axi.bresp   = bresp_reg;
    assign axi.rvalid  = rvalid_reg;
    assign axi.rresp   = rresp_reg;
    assign axi.rdata   = rdata_reg;

    assign aw_hs      = axi.awvalid && axi.awready;
    assign w_hs       = axi.wvalid && axi.wready;
    assign b_hs       = bvalid_reg && axi.bready;
    assign ar_hs      = axi.arvalid && axi.arready;
    assign r_hs       = rvalid_reg && axi.rready;
    assign write_fire = aw_latched_reg && w_latched_reg && !bvalid_reg;
    assign ar_sel     = decode_reg(axi.araddr[7:2]);
    assign rx_read    = ar_hs && (ar_sel == REG_RXDATA);

    assign unused_bits = ^{axi.awaddr[31:8], axi.awaddr[1:0], axi.araddr[31:8],
                           axi.araddr[1:0], axi.wdata[31:16], axi.wstrb[3:2]};

    assign tx_valid = !fifo_empty && tx_en_reg;
    assign tx_data  = fifo_head;
    assign fifo_pop = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (wdata_reg[7:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        bresp_next = RESP_OKAY;
        fifo_push  = 1'b0;
        ctrl_we    = 1'b0;
        ovr_clr    = 1'b0;
        baud_we    = 2'b00;
        if (write_fire) begin
            case (aw_sel_reg)
                REG_TXDATA: begin
                    if (wstrb_reg[0]) begin
                        if (fifo_full) begin
                            bresp_next = RESP_SLVERR;
                        end else begin
                            fifo_push = 1'b1;
                        end
                    end
                end
                REG_RXDATA, REG_STATUS: bresp_next = RESP_SLVERR;
                REG_CTRL: begin
                    ctrl_we = wstrb_reg[0];
                    ovr_clr = wstrb_reg[0] && wdata_reg[CTRL_OVR_CLR];
                end
                REG_BAUD: baud_we = wstrb_reg;
                default:  bresp_next = RESP_DECERR;
            endcase
        end
    end

    always_comb begin
        rdata_next = '0;
        rresp_next = RESP_OKAY;
        case (ar_sel)
            REG_TXDATA: rresp_next = RESP_SLVERR;
            REG_RXDATA: begin
                if (rx_full_reg) begin
                    rdata_next[7:0] = rx_byte_reg;
                end else begin
                    rresp_next = RESP_SLVERR;
                end
            end
            REG_STATUS: begin
                rdata_next[ST_TX_FULL]    = fifo_full;
                rdata_next[ST_TX_EMPTY]   = fifo_empty;
                rdata_next[ST_RX_FULL]    = rx_full_reg;
                rdata_next[ST_RX_OVERRUN] = rx_overrun_reg;
            end
            REG_CTRL: rdata_next[CTRL_TX_EN] = tx_en_reg;
            REG_BAUD: rdata_next[15:0] = baud_div;
            default:  rresp_next = RESP_DECERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_reg       <= 1'b0;
            aw_latched_reg <= 1'b0;
            aw_sel_reg     <= REG_NONE;
            w_latched_reg  <= 1'b0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            bvalid_reg     <= 1'b0;
            bresp_reg      <= RESP_OKAY;
        end else begin
            live_reg <= 1'b1;
            if (aw_hs) begin
                aw_latched_reg <= 1'b1;
                aw_sel_reg     <= decode_reg(axi.awaddr[7:2]);
            end
            if (w_hs) begin
                w_latched_reg <= 1'b1;
                wdata_reg     <= axi.wdata[15:0];
                wstrb_reg     <= axi.wstrb[1:0];
            end
            if (write_fire) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= bresp_next;
            end else if (b_hs) begin
                bvalid_reg     <= 1'b0;
                bresp_reg      <= RESP_OKAY;
                aw_latched_reg <= 1'b0;
                w_latched_reg  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= rresp_next;
            rdata_reg  <= rdata_next;
        end else if (r_hs) begin
            rvalid_reg <= 1'b0;
        end
    end

    // A read accepted in the same cycle frees the slot, so the new byte is taken.
    assign ovr_set = rx_valid && rx_full_reg && !rx_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full_reg    <= 1'b0;
            rx_byte_reg    <= '0;
            rx_overrun_reg <= 1'b0;
            tx_en_reg      <= 1'b1;
        end else begin
            if (rx_valid && !ovr_set) begin
                rx_byte_reg <= rx_data;
                rx_full_reg <= 1'b1;
            end else if (rx_read) begin
                rx_full_reg <= 1'b0;
            end
            rx_overrun_reg <= ovr_set || (rx_overrun_reg && !ovr_clr);
            if (ctrl_we) begin
                tx_en_reg <= wdata_reg[CTRL_TX_EN];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_baud_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= BAUD_RST[gi*8 +: 8];
                end else if (baud_we[gi]) begin
                    lane_reg <= wdata_reg[gi*8 +: 8];
                end
            end
            assign baud_lane[gi] = lane_reg;
        end
    endgenerate

    assign baud_div = {baud_lane[1], baud_lane[0]};

endmodule
